// File: rtl/counter_pkg.sv
// Shared helpers for the T-cell modulo counter: load saturation and the
// carry/borrow toggle chain, sized for the widest legal counter.
package counter_pkg;

  localparam int MAX_WIDTH = 16;

  function automatic logic [15:0] sat_load(input logic [15:0] val, input logic [16:0] mod);
    logic [15:0] res;
    if ({1'b0, val} >= mod) begin
      res = 16'(mod - 17'd1);
    end else begin
      res = val;
    end
    return res;
  endfunction

  // Bit i toggles when every lower bit is 1 (counting up) or 0 (counting down).
  function automatic logic [15:0] toggle_chain(input logic [15:0] q, input logic up);
    logic [15:0] t;
    logic        run;
    t    = 16'h0000;
    t[0] = 1'b1;
    run  = up ? q[0] : ~q[0];
    for (int i = 1; i < 16; i++) begin
      t[i] = run;
      run  = run & (up ? q[i] : ~q[i]);
    end
    return t;
  endfunction

endpackage

// File: rtl/t_ff_bit.sv
// Single T flip-flop cell: toggles on a rising edge while t is high,
// cleared asynchronously by rst_n.
module t_ff_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  assign q_d = q_q ^ t;

  // Toggle state register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/t_mod_counter.sv
// Modulo-MOD up/down counter: builds the toggle vector for a column of
// T cells (carry/borrow chain, wrap, load) and decodes terminal count.
module t_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             div_out
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH || MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_param
    $error("t_mod_counter: illegal WIDTH/MOD combination");
  end

  localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] TERM_DN = WIDTH'(0);
  localparam logic [16:0]      MOD_EXT = 17'(MOD);

  logic [WIDTH-1:0] count_s;
  logic             div_s;
  logic             tc_s;
  logic             at_term_s;
  logic [WIDTH-1:0] term_s;
  logic [WIDTH-1:0] wrap_s;
  logic [WIDTH-1:0] load_sat_s;
  logic [WIDTH-1:0] t_vec_d;
  logic [15:0]      chain_full_s;
  logic [15:0]      sat_full_s;
  logic             unused_s;

  assign sat_full_s   = sat_load(16'(load_val), MOD_EXT);
  assign chain_full_s = toggle_chain(16'(count_s), up);
  assign load_sat_s   = sat_full_s[WIDTH-1:0];
  assign unused_s     = &{1'b0, chain_full_s, sat_full_s};

  assign term_s    = up ? TERM_UP : TERM_DN;
  assign wrap_s    = up ? TERM_DN : TERM_UP;
  assign at_term_s = (count_s == term_s);
  // rst_n gates tc so it reads low while the cells are held in reset.
  assign tc_s      = rst_n & en & ~load & at_term_s;

  // Toggle vector: load > wrap at terminal > carry/borrow chain > hold
  always_comb begin
    t_vec_d = '0;
    if (load) begin
      t_vec_d = count_s ^ load_sat_s;
    end else if (en) begin
      if (at_term_s) begin
        t_vec_d = count_s ^ wrap_s;
      end else begin
        t_vec_d = chain_full_s[WIDTH-1:0];
      end
    end else begin
      t_vec_d = '0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_bit u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t_vec_d[i]),
      .q     (count_s[i])
    );
  end

  t_ff_bit u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .t     (tc_s),
    .q     (div_s)
  );

  assign count   = count_s;
  assign tc      = tc_s;
  assign div_out = div_s;

endmodule

// File: tb/tb_t_mod_counter.sv
// Scoreboard bench: a MOD-10 (4-bit) and a full-range MOD-8 (3-bit) counter
// driven from a directed vector table with hand-computed expectations.
module tb_t_mod_counter;

  typedef struct {
    bit         dut;
    logic       rst;
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] lv;
    logic [3:0] cnt;
    logic       tc;
    logic       div;
  } vec_t;

  typedef struct {
    bit         dut;
    int         idx;
    logic [3:0] cnt;
    logic       tc;
    logic       div;
  } exp_t;

  logic       clk;
  logic       rst_a, en_a, up_a, ld_a, tc_a, div_a;
  logic [3:0] lv_a, cnt_a;
  logic       rst_b, en_b, up_b, ld_b, tc_b, div_b;
  logic [2:0] lv_b, cnt_b;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   drain_req = 1'b0;

  t_mod_counter #(.WIDTH(4), .MOD(10)) u_dut_a (
    .clk(clk), .rst_n(rst_a), .en(en_a), .up(up_a), .load(ld_a),
    .load_val(lv_a), .count(cnt_a), .tc(tc_a), .div_out(div_a)
  );

  t_mod_counter #(.WIDTH(3), .MOD(8)) u_dut_b (
    .clk(clk), .rst_n(rst_b), .en(en_b), .up(up_b), .load(ld_b),
    .load_val(lv_b), .count(cnt_b), .tc(tc_b), .div_out(div_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input bit dut, input logic rst, input logic en, input logic up,
                     input logic ld, input int lv, input int c, input logic t, input logic d);
    vec_t v;
    v.dut = dut; v.rst = rst; v.en = en; v.up = up; v.ld = ld;
    v.lv = 4'(lv); v.cnt = 4'(c); v.tc = t; v.div = d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s row=%0d actual=%0d required=%0d", name, idx, got, want);
    end
  endtask

  // Each row: inputs held for one cycle, expected count/tc/div seen mid-cycle.
  initial begin
    vec_t v;
    exp_t e;
    rst_a = 1'b0; en_a = 1'b0; up_a = 1'b0; ld_a = 1'b0; lv_a = 4'd0;
    rst_b = 1'b0; en_b = 1'b0; up_b = 1'b0; ld_b = 1'b0; lv_b = 3'd0;

    // DUT A: reset (tc stays low even with en=1, up=0, count=0), then hold
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 1, 0, 0, 0, 0, 0);
    // Up wrap: 12 enabled edges
    add(0, 1, 1, 1, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 8; c++) add(0, 1, 1, 1, 0, 0, c, 0, 0);
    add(0, 1, 1, 1, 0, 0, 9, 1, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 1);
    add(0, 1, 1, 1, 0, 0, 1, 0, 1);
    // Down wrap from loaded 2
    add(0, 1, 0, 1, 1, 2, 2, 0, 1);
    add(0, 1, 1, 0, 0, 0, 2, 0, 1);
    add(0, 1, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 1, 0, 0, 0, 0, 1, 1);
    add(0, 1, 1, 0, 0, 0, 9, 0, 0);
    add(0, 1, 0, 0, 0, 0, 8, 0, 0);
    // Load priority and saturation
    add(0, 1, 0, 0, 1, 5, 8, 0, 0);
    add(0, 1, 1, 1, 1, 13, 5, 0, 0);
    add(0, 1, 1, 1, 1, 3, 9, 0, 0);
    add(0, 1, 0, 1, 0, 0, 3, 0, 0);
    // Direction flip from 4
    add(0, 1, 0, 1, 1, 4, 3, 0, 0);
    add(0, 1, 1, 1, 0, 0, 4, 0, 0);
    add(0, 1, 1, 0, 0, 0, 5, 0, 0);
    add(0, 1, 1, 0, 0, 0, 4, 0, 0);
    add(0, 1, 0, 0, 0, 0, 3, 0, 0);
    // Async reset mid-run at 7
    add(0, 1, 0, 0, 1, 7, 3, 0, 0);
    add(0, 1, 0, 0, 0, 0, 7, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0);
    // Load exactly MOD saturates
    add(0, 1, 0, 0, 1, 10, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 9, 0, 0);
    // DUT B: full-range up 9 edges, then natural borrow wrap
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 6; c++) add(1, 1, 1, 1, 0, 0, c, 0, 0);
    add(1, 1, 1, 1, 0, 0, 7, 1, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 1);
    add(1, 1, 0, 1, 0, 0, 1, 0, 1);
    add(1, 1, 1, 0, 0, 0, 1, 0, 1);
    add(1, 1, 1, 0, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 0, 7, 0, 0);

    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      v = vecs[k];
      if (v.dut == 1'b0) begin
        rst_a = v.rst; en_a = v.en; up_a = v.up; ld_a = v.ld; lv_a = v.lv;
      end else begin
        rst_b = v.rst; en_b = v.en; up_b = v.up; ld_b = v.ld; lv_b = v.lv[2:0];
      end
      e.dut = v.dut; e.idx = k; e.cnt = v.cnt; e.tc = v.tc; e.div = v.div;
      exp_q.push_back(e);
    end
    drain_req = 1'b1;
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  exp_t       m_e;
  logic [3:0] got_c;
  logic       got_t, got_d;
  bit         drained = 1'b0;

  // Monitor: pops the pending expectation each mid-cycle and compares
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      if (m_e.dut == 1'b0) begin
        got_c = cnt_a; got_t = tc_a; got_d = div_a;
      end else begin
        got_c = {1'b0, cnt_b}; got_t = tc_b; got_d = div_b;
      end
      check(m_e.dut ? "count_b" : "count_a", m_e.idx, int'(got_c), int'(m_e.cnt));
      check(m_e.dut ? "tc_b" : "tc_a", m_e.idx, int'(got_t), int'(m_e.tc));
      check(m_e.dut ? "div_b" : "div_a", m_e.idx, int'(got_d), int'(m_e.div));
    end else if (drain_req && !drained) begin
      drained = 1'b1;
      check("drain_pending", -1, exp_q.size(), 0);
    end
  end

endmodule
